dmux_dispatch: RTL and testbench

Upstream feeder for the 16-way demultiplexer: accepts a stream of (data, destination) words over a valid/ready handshake, buffers them in a small FIFO, and presents each one on `inn`/`sel` for a fixed number of cycles. `inn`/`sel` are stable at all other times, so the demux never sees a stray write. With the broadcast option enabled, a single word can be swept across all 16 destinations.

---
 rtl/dmux_disp_pkg.sv | 13 +
 rtl/dmux_disp_fifo.sv | 41 ++++
 rtl/dmux_dispatch.sv | 101 ++++++++++
 tb/tb_dmux_dispatch.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dmux_disp_pkg.sv
// dmux_disp_pkg: shared FSM states, default sizes and FIFO entry layout for dmux_dispatch
package dmux_disp_pkg;
  localparam int DW_DEF = 5;
  localparam int SW_DEF = 4;
  localparam int DEPTH_DEF = 4;
  localparam int HOLD_DEF = 2;
  typedef enum logic {ST_IDLE, ST_DRIVE} state_t;
  typedef struct packed {
    logic bcast;
    logic [SW_DEF-1:0] sel;
    logic [DW_DEF-1:0] data;
  } entry_t;
endpackage

// File: rtl/dmux_disp_fifo.sv
// dmux_disp_fifo: synchronous FIFO with occupancy count; pointers wrap modulo DEPTH
module dmux_disp_fifo #(
  parameter int W = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wp_d = push ? wp_q + AW'(1) : wp_q;
    rp_d = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
    if (push) mem_q[wp_q] <= wdata;
  end
  assign rdata = mem_q[rp_q];
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/dmux_dispatch.sv
// dmux_dispatch: FIFO-buffered feeder presenting each word on inn/sel for HOLD cycles.
// Define DMUX_DISP_BCAST_EN to add in_bcast, sweeping one word across every sel value.
module dmux_dispatch import dmux_disp_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int HOLD = HOLD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DW-1:0]            in_data,
  input  logic [SW-1:0]            in_sel,
`ifdef DMUX_DISP_BCAST_EN
  input  logic                     in_bcast,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DW-1:0]            inn,
  output logic [SW-1:0]            sel,
  output logic                     out_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int CW = $clog2(HOLD) + 1;
`ifdef DMUX_DISP_BCAST_EN
  localparam int EW = DW + SW + 1;
`else
  localparam int EW = DW + SW;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] inn_q, inn_d;
  logic [SW-1:0] sel_q, sel_d;
  logic ov_q, ov_d, bc_q, bc_d, rdy_q, rdy_d;
  logic push, pop, full, empty, head_bc;
  logic [EW-1:0] wdata, head;
`ifdef DMUX_DISP_BCAST_EN
  assign wdata = {in_bcast, in_sel, in_data};
  assign head_bc = head[EW-1];
`else
  assign wdata = {in_sel, in_data};
  assign head_bc = 1'b0;
`endif
  // rdy_q keeps in_ready low through reset and raises it on the first edge after release
  assign in_ready = rdy_q && !full;
  assign push = in_valid && in_ready;
  dmux_disp_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .wdata(wdata),
    .rdata(head), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    inn_d = inn_q;
    sel_d = sel_q;
    ov_d = ov_q;
    bc_d = bc_q;
    rdy_d = 1'b1;
    pop = 1'b0;
    if (state_q == ST_DRIVE && cnt_q != '0) cnt_d = cnt_q - CW'(1);
    else if (state_q == ST_DRIVE && bc_q && sel_q != '1) begin
      sel_d = sel_q + SW'(1);
      cnt_d = CW'(HOLD - 1);
    end else if (!empty) begin
      pop = 1'b1;
      inn_d = head[DW-1:0];
      sel_d = head_bc ? '0 : head[DW+SW-1:DW];
      bc_d = head_bc;
      ov_d = 1'b1;
      cnt_d = CW'(HOLD - 1);
      state_d = ST_DRIVE;
    end else begin
      ov_d = 1'b0;
      bc_d = 1'b0;
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      inn_q <= '0;
      sel_q <= '0;
      ov_q <= 1'b0;
      bc_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      inn_q <= inn_d;
      sel_q <= sel_d;
      ov_q <= ov_d;
      bc_q <= bc_d;
      rdy_q <= rdy_d;
    end
  end
  assign inn = inn_q;
  assign sel = sel_q;
  assign out_valid = ov_q;
  assign busy = state_q != ST_IDLE || !empty;
endmodule

// File: tb/tb_dmux_dispatch.sv
// tb_dmux_dispatch: directed self-checking bench for dmux_dispatch (default sizes, HOLD=2, DEPTH=4)
module tb_dmux_dispatch;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] in_data;
  logic [3:0] in_sel;
`ifdef DMUX_DISP_BCAST_EN
  logic in_bcast;
`endif
  logic in_valid, in_ready, out_valid, busy;
  logic [4:0] inn;
  logic [3:0] sel;
  logic [2:0] count;
  int n_chk = 0;
  int n_fail = 0;
  int i;
  logic acc;

  always #5 clk = ~clk;

  dmux_dispatch dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
`ifdef DMUX_DISP_BCAST_EN
    .in_bcast(in_bcast),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .inn(inn), .sel(sel),
    .out_valid(out_valid), .busy(busy), .count(count)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [4:0] d, input logic [3:0] s);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".inn"}, 32'(inn), 32'(d));
    chk({tag, ".sel"}, 32'(sel), 32'(s));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 5'h15;
    in_sel = 4'h9;
`ifdef DMUX_DISP_BCAST_EN
    in_bcast = 1'b0;
`endif
    repeat (3) step();
    chk_out("reset", 1'b0, 5'h00, 4'h0);
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();
    chk("release.in_ready", 32'(in_ready), 32'd1);
    chk("release.count", 32'(count), 32'd0);

    // single word
    in_valid = 1'b1;
    in_data = 5'h0A;
    in_sel = 4'h3;
    step();
    in_valid = 1'b0;
    chk("single.count", 32'(count), 32'd1);
    chk("single.pre_valid", 32'(out_valid), 32'd0);
    step();
    chk_out("single.c1", 1'b1, 5'h0A, 4'h3);
    chk("single.busy", 32'(busy), 32'd1);
    step();
    chk_out("single.c2", 1'b1, 5'h0A, 4'h3);
    step();
    chk_out("single.idle", 1'b0, 5'h0A, 4'h3);
    chk("single.idle_busy", 32'(busy), 32'd0);

    // back-to-back: 5 words pushed on consecutive edges
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1;
      in_data = 5'(k);
      in_sel = 4'(k - 1);
      step();
    end
    in_valid = 1'b0;
    chk("b2b.count_after_push", 32'(count), 32'd3);
    // the fifth edge showed word 2 at its second cycle; walk the rest
    chk_out("b2b.w2b", 1'b1, 5'h02, 4'h1);
    for (int k = 4; k <= 9; k++) begin
      step();
      chk_out("b2b.stream", 1'b1, 5'(k / 2 + 1), 4'(k / 2));
    end
    step();
    chk_out("b2b.idle", 1'b0, 5'h05, 4'h4);

    // fill to full while the FSM keeps popping
    i = 0;
    in_valid = 1'b1;
    in_data = 5'h10;
    in_sel = 4'h0;
    for (int c = 1; c <= 9; c++) begin
      acc = in_ready;
      step();
      if (acc) i++;
      in_data = 5'(16 + i);
      in_sel = 4'(i);
      if (c == 7) begin
        chk("full.count7", 32'(count), 32'd4);
        chk("full.ready7", 32'(in_ready), 32'd0);
      end
      if (c == 8) begin
        chk("full.count8", 32'(count), 32'd3);
        chk("full.ready8", 32'(in_ready), 32'd1);
      end
      if (c == 9) begin
        chk("full.count9", 32'(count), 32'd4);
        chk("full.ready9", 32'(in_ready), 32'd0);
      end
    end
    in_valid = 1'b0;
    chk("full.accepted", 32'(i), 32'd8);
    chk_out("full.live", 1'b1, 5'h13, 4'h3);

    // reset mid-operation with a full queue
    rst_n = 1'b0;
    step();
    chk_out("midrst", 1'b0, 5'h00, 4'h0);
    chk("midrst.count", 32'(count), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("midrst.quiet", 32'(out_valid), 32'd0);
    end

`ifdef DMUX_DISP_BCAST_EN
    // broadcast sweep
    in_valid = 1'b1;
    in_data = 5'h1F;
    in_sel = 4'h7;
    in_bcast = 1'b1;
    step();
    in_valid = 1'b0;
    in_bcast = 1'b0;
    for (int k = 0; k < 32; k++) begin
      step();
      chk_out("bcast.sweep", 1'b1, 5'h1F, 4'(k / 2));
    end
    step();
    chk_out("bcast.idle", 1'b0, 5'h1F, 4'hF);

    // reset during a broadcast at sel 6 with two words queued
    in_valid = 1'b1;
    in_data = 5'h1F;
    in_sel = 4'h7;
    in_bcast = 1'b1;
    step();
    in_bcast = 1'b0;
    in_data = 5'h0C;
    in_sel = 4'h2;
    step();
    in_data = 5'h0D;
    in_sel = 4'h5;
    step();
    in_valid = 1'b0;
    repeat (11) step();
    chk_out("bcrst.pre", 1'b1, 5'h1F, 4'h6);
    chk("bcrst.pre_count", 32'(count), 32'd2);
    rst_n = 1'b0;
    step();
    chk_out("bcrst", 1'b0, 5'h00, 4'h0);
    chk("bcrst.count", 32'(count), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bcrst.quiet", 32'(out_valid), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
